gamepad_pmod_tx: RTL and testbench

Transmitter end of the gamepad Pmod serial link. It takes parallel button states for one or two controllers and serializes them onto the three-wire bus (`pmod_data`, `pmod_clk`, `pmod_latch`). The bus waveform matches what the on-chip gamepad receiver samples. The block serves as a loopback/self-test source and as a gamepad emulator when the design drives another board.

---
 rtl/gamepad_pmod_pkg.sv | 38 +++
 rtl/pmod_phase_timer.sv | 41 ++++
 rtl/gamepad_pmod_tx.sv | 175 +++++++++++++++++
 tb/tb_gamepad_pmod_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pmod_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gamepad_pmod_pkg : button map, frame widths and FSM states shared   |
// | by the gamepad Pmod transmitter and receiver.        Rev 1.0       |
// +--------------------------------------------------------------------+
package gamepad_pmod_pkg;

  localparam int BTN_WIDTH = 12;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  localparam int FRAME_W_SINGLE = BTN_WIDTH;
  localparam int FRAME_W_DUAL   = 2 * BTN_WIDTH;

  localparam int TIMER_W   = 16;
  localparam int BIT_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LATCH = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/pmod_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmod_phase_timer : loadable down-counter; tc is high while the      |
// | count sits at zero.                                  Rev 1.0       |
// +--------------------------------------------------------------------+
module pmod_phase_timer
  import gamepad_pmod_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               tc
);

  localparam logic [TIMER_W-1:0] C_ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/gamepad_pmod_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gamepad_pmod_tx : serializes controller button states onto the     |
// | Pmod data/clk/latch bus. GAMEPAD_TX_DUAL_EN adds controller 2.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gamepad_pmod_tx
  import gamepad_pmod_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8,
  parameter int FRAME_GAP    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BTN_WIDTH-1:0] buttons1,
  input  logic [BTN_WIDTH-1:0] buttons2,
  output logic                 pmod_data,
  output logic                 pmod_clk,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);

`ifdef GAMEPAD_TX_DUAL_EN
  localparam int FRAME_W = FRAME_W_DUAL;
  logic [FRAME_W-1:0] frame_word;
  assign frame_word = {buttons2, buttons1};
`else
  localparam int FRAME_W = FRAME_W_SINGLE;
  logic [FRAME_W-1:0] frame_word;
  logic               unused_buttons2;
  assign frame_word      = buttons1;
  assign unused_buttons2 = ^buttons2;
`endif

  // Timer reloads hold N-1 so a state lasts exactly N cycles.
  localparam logic [TIMER_W-1:0]   C_LD_HALF  = TIMER_W'(CLK_DIV - 1);
  localparam logic [TIMER_W-1:0]   C_LD_LATCH = TIMER_W'(LATCH_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   C_LD_GAP   = TIMER_W'(FRAME_GAP - 1);
  localparam logic [BIT_IDX_W-1:0] C_IDX_TOP  = BIT_IDX_W'(FRAME_W - 1);
  localparam logic [BIT_IDX_W-1:0] C_IDX_ONE  = BIT_IDX_W'(1);

  tx_state_e            state_q,   state_d;
  logic [FRAME_W-1:0]   shift_q,   shift_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 data_q,    data_d;
  logic                 sclk_q,    sclk_d;
  logic                 latch_q,   latch_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_tc;
  logic               start_frame;

  pmod_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    data_d      = data_q;
    sclk_d      = sclk_q;
    latch_d     = latch_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_frame = enable;
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_HIGH;
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = C_LD_HALF;
        end
      end
      ST_HIGH: begin
        if (tmr_tc) begin
          sclk_d   = 1'b0;
          tmr_load = 1'b1;
          if (bit_idx_q == '0) begin
            state_d = ST_LATCH;
            latch_d = 1'b1;
            tmr_val = C_LD_LATCH;
          end else begin
            state_d   = ST_SETUP;
            bit_idx_d = bit_idx_q - C_IDX_ONE;
            data_d    = shift_q[FRAME_W-2];
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            tmr_val   = C_LD_HALF;
          end
        end
      end
      ST_LATCH: begin
        if (tmr_tc) begin
          state_d  = ST_GAP;
          latch_d  = 1'b0;
          done_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = C_LD_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Snapshot and first bit are taken together so the whole frame is coherent.
    if (start_frame) begin
      state_d   = ST_SETUP;
      busy_d    = 1'b1;
      shift_d   = frame_word;
      data_d    = frame_word[FRAME_W-1];
      bit_idx_d = C_IDX_TOP;
      tmr_load  = 1'b1;
      tmr_val   = C_LD_HALF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pmod_data  = data_q;
  assign pmod_clk   = sclk_q;
  assign pmod_latch = latch_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_pmod_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gamepad_pmod_tx : directed frames with a receiver-model monitor  |
// | checking words against a queue of expected frames.   Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_gamepad_pmod_tx;

  localparam int CLK_DIV      = 2;
  localparam int LATCH_CYCLES = 8;
  localparam int FRAME_GAP    = 64;
`ifdef GAMEPAD_TX_DUAL_EN
  localparam int FRAME_W = 24;
`else
  localparam int FRAME_W = 12;
`endif
  localparam int PERIOD = 2 * CLK_DIV * FRAME_W + LATCH_CYCLES + FRAME_GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] buttons1 = 12'h000;
  logic [11:0] buttons2 = 12'h000;
  logic        pmod_data, pmod_clk, pmod_latch, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int clk_rises   = 0;
  int latch_rises = 0;
  logic [23:0] exp_q[$];

  gamepad_pmod_tx #(
    .CLK_DIV      (CLK_DIV),
    .LATCH_CYCLES (LATCH_CYCLES),
    .FRAME_GAP    (FRAME_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .pmod_data  (pmod_data),
    .pmod_clk   (pmod_clk),
    .pmod_latch (pmod_latch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame as the receiver would assemble it, per build mode.
  task automatic push_exp(input logic [23:0] dual_v, input logic [11:0] single_v);
`ifdef GAMEPAD_TX_DUAL_EN
    exp_q.push_back(dual_v);
`else
    exp_q.push_back({12'h000, single_v});
`endif
  endtask

  task automatic wait_done(output int t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 2000);
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_rises(input int n);
    int   k;
    int   seen;
    logic prev;
    k = 0; seen = 0; prev = pmod_clk;
    while (seen < n && k < 2000) begin
      @(negedge clk);
      k++;
      if (pmod_clk && !prev) seen++;
      prev = pmod_clk;
    end
    check("rises_seen", seen, n);
  endtask

  // Receiver model plus bus-protocol checks.
  logic        prev_clk = 1'b0, prev_latch = 1'b0, prev_data = 1'b0;
  int          latch_len = 0;
  int          nbits = 0;
  logic [23:0] rx_word = 24'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      rx_word = 24'h0;
      latch_len = 0;
    end else begin
      if (pmod_clk && !prev_clk) begin
        rx_word = {rx_word[22:0], pmod_data};
        nbits++;
        clk_rises++;
      end
      if (pmod_data !== prev_data && pmod_clk && prev_clk)
        check("data_stable_while_clk_high", {31'd0, pmod_data}, {31'd0, prev_data});
      if (pmod_latch && !prev_latch) begin
        latch_rises++;
        check("bit_count", nbits, FRAME_W);
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else check("frame_word", {8'd0, rx_word}, {8'd0, exp_q.pop_front()});
        nbits = 0;
        rx_word = 24'h0;
      end
      if (pmod_latch) latch_len++;
      if ((prev_latch && !pmod_latch) || frame_done) begin
        check("done_at_latch_fall", {29'd0, frame_done, prev_latch, pmod_latch}, 32'b110);
        check("latch_width", latch_len, LATCH_CYCLES);
        latch_len = 0;
      end
    end
    prev_clk   = pmod_clk;
    prev_latch = pmod_latch;
    prev_data  = pmod_data;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_b, t_c, t_e, t_f, k, r0, l0;

    repeat (3) @(negedge clk);
    check("rst_data",  {31'd0, pmod_data},  32'd0);
    check("rst_clk",   {31'd0, pmod_clk},   32'd0);
    check("rst_latch", {31'd0, pmod_latch}, 32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_low", {31'd0, busy}, 32'd0);

    // Frame A: A button of controller 1 only.
    buttons1 = 12'h008; buttons2 = 12'h000;
    push_exp(24'h000008, 12'h008);
    enable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_rise", {31'd0, busy}, 32'd1);
    end while (!pmod_clk && k < 50);
    check("first_rise_latency", k, CLK_DIV + 1);
    wait_done(t_a);

    // Frame B: loopback pattern, loaded during the gap.
    buttons1 = 12'h0F0; buttons2 = 12'hA05;
    push_exp(24'hA050F0, 12'h0F0);
    wait_done(t_b);
    check("frame_period", t_b - t_a, PERIOD);

    // Frames C/D: mid-frame change is deferred to the next frame.
    buttons1 = 12'h000; buttons2 = 12'h000;
    push_exp(24'h000000, 12'h000);
    wait_rises(10);
    buttons1 = 12'hFFF;
    push_exp(24'h000FFF, 12'hFFF);
    wait_done(t_c);
    wait_done(t_c);

    // Frame E: enable dropped mid-frame.
    push_exp(24'h000FFF, 12'hFFF);
    wait_rises(5);
    enable = 1'b0;
    wait_done(t_e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 500);
    t_f = cyc;
    check("busy_fall_after_gap", t_f - t_e, FRAME_GAP);
    r0 = clk_rises;
    repeat (100) @(negedge clk);
    check("no_clk_after_disable", clk_rises, r0);
    check("idle_after_disable", {31'd0, busy}, 32'd0);

    // Reset while pmod_clk is high in HIGH.
    buttons1 = 12'hFFF;
    enable = 1'b1;
    wait_rises(3);
    check("clk_high_before_reset", {31'd0, pmod_clk}, 32'd1);
    l0 = latch_rises;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_data",  {31'd0, pmod_data},  32'd0);
    check("mid_rst_clk",   {31'd0, pmod_clk},   32'd0);
    check("mid_rst_latch", {31'd0, pmod_latch}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_done",  {31'd0, frame_done}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no_latch_after_reset", latch_rises, l0);
    check("idle_after_reset", {31'd0, busy}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
